ky32_reg_arbiter: RTL and testbench

- Round-robin arbiter sharing one WIDTH-bit holding register (single write port) among NREQ requesters.
- Each cycle it grants at most one requester and loads that requester's data into the register.
- Supports a lock so one requester can perform back-to-back burst writes without interleaving.
- Sits between KY32 producer units (e.g. execute/load/CSR paths) and a shared result/staging register.

---
 rtl/ky32_reg_arbiter_pkg.sv | 13 +
 rtl/ky32_rr_pick.sv | 38 +++
 rtl/ky32_reg_arbiter.sv | 132 +++++++++++++
 tb/tb_ky32_reg_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ky32_reg_arbiter_pkg.sv
// Shared definitions for the KY32 result-register arbiter: FSM state encoding
// and default geometry used by the arbiter top level and its picker.
package ky32_reg_arbiter_pkg;

  localparam int unsigned ARB_NREQ_DEFAULT  = 4;
  localparam int unsigned ARB_WIDTH_DEFAULT = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ky32_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_i,
// wrapping to 0, found by a double-width masked priority encode.
module ky32_rr_pick
  import ky32_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ_DEFAULT,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [NREQ-1:0] pick_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] dbl;
  logic              found;

  // Lower half holds only requesters above last_i; upper half is the unmasked wrap.
  always_comb begin
    dbl    = {req_i, req_i};
    found  = 1'b0;
    idx_o  = '0;
    pick_o = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      dbl[i] = req_i[i] & (IDXW'(i) > last_i);
    end
    for (int i = 0; i < 2 * int'(NREQ); i++) begin
      idx_o = (!found && dbl[i]) ? IDXW'(i % int'(NREQ)) : idx_o;
      found = found | dbl[i];
    end
    any_o = found;
    for (int i = 0; i < int'(NREQ); i++) begin
      pick_o[i] = found & (idx_o == IDXW'(i));
    end
  end

endmodule

// File: rtl/ky32_reg_arbiter.sv
// Round-robin arbiter sharing one holding register among NREQ producers, with
// a per-requester lock that lets the current owner write an uninterrupted burst.
module ky32_reg_arbiter
  import ky32_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = ARB_NREQ_DEFAULT,
  parameter int unsigned WIDTH = ARB_WIDTH_DEFAULT,
  parameter int unsigned IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [IDXW-1:0]       q_src,
  output logic                  locked
);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] src_q, src_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [WIDTH-1:0] data_q;

  logic [IDXW-1:0]  scan_from;
  logic [NREQ-1:0]  pick_oh;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;
  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;

  // An abandoned lock restarts the scan just after the former owner.
  assign scan_from = (state_q == ARB_LOCKED) ? owner_q : last_q;

  ky32_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i  (req),
    .last_i (scan_from),
    .pick_o (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Select the writer for this edge and derive every next-state value from it.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    src_d   = src_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = pick_idx;
    case (state_q)
      ARB_IDLE: begin
        wr_en  = pick_any;
        wr_idx = pick_idx;
      end
      ARB_LOCKED: begin
        if (req[owner_q]) begin
          wr_en  = 1'b1;
          wr_idx = owner_q;
        end else begin
          wr_en  = pick_any;
          wr_idx = pick_idx;
        end
      end
      default: begin
        wr_en  = 1'b0;
        wr_idx = pick_idx;
      end
    endcase

    if (wr_en) begin
      last_d         = wr_idx;
      owner_d        = wr_idx;
      src_d          = wr_idx;
      valid_d        = 1'b1;
      gnt_d[wr_idx]  = 1'b1;
      state_d        = lock[wr_idx] ? ARB_LOCKED : ARB_IDLE;
    end else begin
      state_d = ARB_IDLE;
    end
  end

  assign wr_data = wdata[wr_idx*WIDTH +: WIDTH];

  // Control and status registers; reset drops any lock in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= IDXW'(NREQ - 1);
      owner_q <= '0;
      src_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  // Shared holding register, loaded only on a granted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (wr_en) begin
      data_q <= wr_data;
    end else begin
      data_q <= data_q;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign q_src   = src_q;
  assign locked  = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_ky32_reg_arbiter.sv
// Self-checking bench for ky32_reg_arbiter: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model of the grant rules.
module tb_ky32_reg_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [1:0]     q_src;
  logic           locked;

  int total = 0;
  int bad   = 0;

  // Reference model state: who was served last, whether a burst is open and by whom.
  int         m_last;
  int         m_owner;
  bit         m_burst;
  logic [3:0] m_gnt;
  logic [31:0] m_q;
  bit         m_valid;
  logic [1:0] m_src;

  ky32_reg_arbiter #(.NREQ(N), .WIDTH(W), .IDXW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_last  = N - 1;
    m_owner = 0;
    m_burst = 0;
    m_gnt   = 4'h0;
    m_q     = 32'h0;
    m_valid = 0;
    m_src   = 2'd0;
  endtask

  // One clock edge of the arbitration rules, evaluated on the sampled inputs.
  task automatic model_step();
    int w;
    int start;
    int c;
    w = -1;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_burst && req[m_owner]) begin
      w = m_owner;
    end else begin
      start = m_burst ? m_owner : m_last;
      for (int k = 1; k <= N; k++) begin
        c = (start + k) % N;
        if (w < 0 && req[c]) w = c;
      end
    end
    m_gnt   = 4'h0;
    m_valid = 0;
    if (w >= 0) begin
      m_gnt[w] = 1'b1;
      m_q      = wdata[w*W +: W];
      m_valid  = 1;
      m_src    = 2'(w);
      m_last   = w;
      m_owner  = w;
      m_burst  = lock[w];
    end else begin
      m_burst = 0;
    end
  endtask

  function automatic logic [39:0] model_vec();
    return {m_gnt, m_q, m_valid, m_src, m_burst};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'h0;
    lock = 4'h0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    req   = 4'($urandom_range(0, 15));
    lock  = 4'($urandom_range(0, 15));
    wdata = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    step();
    step();
    total++;
    if ({gnt, q, q_valid, q_src, locked} !== 40'h0) begin
      bad++;
      $display("FAIL reset_hold: got gnt=%b q=%h v=%b src=%0d lk=%b want all zero",
               gnt, q, q_valid, q_src, locked);
    end
    rst  = 1'b1;
    req  = 4'h0;
    lock = 4'h0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (gnt !== 4'h0 || q !== 32'h0 || q_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got gnt=%b q=%h v=%b want 0000/0/0", c, gnt, q, q_valid);
      end
    end
  endtask

  task automatic test_single();
    wdata = {$urandom, $urandom, $urandom, $urandom};
    wdata[2*W +: W] = 32'hDEADBEEF;
    req = 4'b0100;
    step();
    req = 4'h0;
    total++;
    if (gnt !== 4'b0100 || q !== 32'hDEADBEEF || q_src !== 2'd2 || q_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_write: got gnt=%b q=%h src=%0d v=%b want 0100 deadbeef 2 1",
               gnt, q, q_src, q_valid);
    end
    step();
    total++;
    if (gnt !== 4'h0 || q !== 32'hDEADBEEF || q_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_hold: got gnt=%b q=%h v=%b want 0000 deadbeef 0", gnt, q, q_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 32'(i + 1);
    req  = 4'b1111;
    lock = 4'h0;
    for (int c = 0; c < 8; c++) begin
      step();
      exp_g = 4'b0001 << (c % 4);
      total++;
      if (gnt !== exp_g || q !== 32'((c % 4) + 1) || {gnt, q, q_valid, q_src, locked} !== model_vec()) begin
        bad++;
        $display("FAIL round_robin cyc%0d: got gnt=%b q=%h want gnt=%b q=%h", c, gnt, q, exp_g, 32'((c % 4) + 1));
      end
    end
  endtask

  task automatic test_lock_burst();
    logic [31:0] beat [3];
    beat[0] = 32'hA0A0_0001;
    beat[1] = 32'hB0B0_0002;
    beat[2] = 32'hC0C0_0003;
    do_reset();
    wdata = {$urandom, $urandom, $urandom, $urandom};
    req = 4'b0001;
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL burst_pre: got gnt=%b want 0001", gnt);
    end
    for (int b = 0; b < 3; b++) begin
      req  = 4'b1010;
      lock = (b < 2) ? 4'b0010 : 4'b0000;
      wdata[1*W +: W] = beat[b];
      step();
      total++;
      if (gnt !== 4'b0010 || q !== beat[b] || locked !== (b < 2)) begin
        bad++;
        $display("FAIL burst_beat%0d: got gnt=%b q=%h lk=%b want 0010 %h %b", b, gnt, q, locked, beat[b], b < 2);
      end
    end
    req  = 4'b1000;
    lock = 4'h0;
    step();
    total++;
    if (gnt !== 4'b1000 || q !== wdata[3*W +: W] || locked !== 1'b0) begin
      bad++;
      $display("FAIL burst_after: got gnt=%b q=%h lk=%b want 1000 %h 0", gnt, q, locked, wdata[3*W +: W]);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};
    req  = 4'b0100;
    lock = 4'b0100;
    step();
    req  = 4'b0101;
    step();
    total++;
    if (gnt !== 4'b0100 || locked !== 1'b1 || q !== 32'h2222_2222) begin
      bad++;
      $display("FAIL abandon_locked: got gnt=%b lk=%b q=%h want 0100 1 22222222", gnt, locked, q);
    end
    req  = 4'b0001;
    lock = 4'h0;
    wdata[2*W +: W] = 32'hFFFF_FFFF;
    step();
    total++;
    if (gnt !== 4'b0001 || locked !== 1'b0 || q !== 32'h0BAD_0000 || q_src !== 2'd0) begin
      bad++;
      $display("FAIL abandon_switch: got gnt=%b lk=%b q=%h src=%0d want 0001 0 0bad0000 0", gnt, locked, q, q_src);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wdata = {$urandom, $urandom, $urandom, $urandom};
    req  = 4'b0010;
    lock = 4'b0010;
    step();
    step();
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: got lk=%b want 1", locked);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (locked !== 1'b0 || gnt !== 4'h0 || q !== 32'h0 || q_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got lk=%b gnt=%b q=%h v=%b want 0 0000 0 0", locked, gnt, q, q_valid);
    end
    req  = 4'b1111;
    lock = 4'h0;
    #2 rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL async_first: got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      req   = 4'($urandom_range(0, 15));
      lock  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wdata = {$urandom, $urandom, $urandom, $urandom};
      step();
      total++;
      if ({gnt, q, q_valid, q_src, locked} !== model_vec() || !$onehot0(gnt)) begin
        bad++;
        $display("FAIL random cyc%0d: got gnt=%b q=%h v=%b src=%0d lk=%b want gnt=%b q=%h v=%b src=%0d lk=%b",
                 c, gnt, q, q_valid, q_src, locked, m_gnt, m_q, m_valid, m_src, m_burst);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst   = 1'b0;
    req   = 4'h0;
    lock  = 4'h0;
    wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_burst();
    test_abandon();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
